// File: rtl/me_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : me_frame_sequencer
// Description : Frame-level driver for the hexbs_top motion-estimation core.
//               Walks all macroblocks of a frame in raster order, issues one
//               core start per MB and queues {mb_x, mb_y, mv_x, mv_y, sad}
//               in a first-word fall-through result FIFO. Includes a per-MB
//               watchdog and an abort input that flushes the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module me_frame_sequencer #(
    parameter int FRAME_WIDTH     = 352,
    parameter int FRAME_HEIGHT    = 240,
    parameter int MB_SIZE         = 16,
    parameter int ADDR_W          = 32,
    parameter int MV_W            = 6,
    parameter int SAD_W           = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int WATCHDOG_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              frame_idx,
    input  logic                     abort,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     timeout_err,
    output logic                     cfg_err,
    output logic [15:0]              mb_count,
    output logic                     me_start,
    output logic [ADDR_W-1:0]        me_frame_addr,
    output logic [ADDR_W-1:0]        me_ref_addr,
    output logic [ADDR_W-1:0]        me_mb_x,
    output logic [ADDR_W-1:0]        me_mb_y,
    input  logic signed [MV_W-1:0]   me_mv_x,
    input  logic signed [MV_W-1:0]   me_mv_y,
    input  logic [SAD_W-1:0]         me_sad,
    input  logic                     me_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [ADDR_W-1:0]        res_mb_x,
    output logic [ADDR_W-1:0]        res_mb_y,
    output logic signed [MV_W-1:0]   res_mv_x,
    output logic signed [MV_W-1:0]   res_mv_y,
    output logic [SAD_W-1:0]         res_sad
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    localparam int c_ENTRY_W = 2 * ADDR_W + 2 * MV_W + SAD_W;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_WD_W    = $clog2(WATCHDOG_CYCLES);

    localparam logic [ADDR_W-1:0]  c_MB_STEP = ADDR_W'(MB_SIZE);
    localparam logic [ADDR_W-1:0]  c_X_LAST  = ADDR_W'(FRAME_WIDTH - MB_SIZE);
    localparam logic [ADDR_W-1:0]  c_Y_LAST  = ADDR_W'(FRAME_HEIGHT - MB_SIZE);
    localparam logic [ADDR_W-1:0]  c_PIX     = ADDR_W'(FRAME_WIDTH * FRAME_HEIGHT);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST = c_WD_W'(WATCHDOG_CYCLES - 1);

    generate
        if ((FRAME_WIDTH % MB_SIZE) != 0) begin : g_chk_width
            $error("FRAME_WIDTH must be a multiple of MB_SIZE");
        end
        if ((FRAME_HEIGHT % MB_SIZE) != 0) begin : g_chk_height
            $error("FRAME_HEIGHT must be a multiple of MB_SIZE");
        end
        if (FIFO_DEPTH < 2) begin : g_chk_depth
            $error("FIFO_DEPTH must be at least 2");
        end
        if (WATCHDOG_CYCLES < 2) begin : g_chk_wd
            $error("WATCHDOG_CYCLES must be at least 2");
        end
    endgenerate

    logic [1:0]           r_state;
    logic [c_WD_W-1:0]    r_wd;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];

    logic                 w_full;
    logic                 w_done_q;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last_mb;
    logic [ADDR_W-1:0]    w_frame_addr;
    logic [ADDR_W-1:0]    w_ref_addr;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic [ADDR_W-1:0]    w_h_x;
    logic [ADDR_W-1:0]    w_h_y;
    logic signed [MV_W-1:0] w_h_mvx;
    logic signed [MV_W-1:0] w_h_mvy;
    logic [SAD_W-1:0]     w_h_sad;

    // Products taken modulo 2^ADDR_W: identical to the full-width product truncated.
    assign w_frame_addr = ADDR_W'(frame_idx) * c_PIX;
    assign w_ref_addr   = ADDR_W'(frame_idx - 16'd1) * c_PIX;

    assign w_full    = (r_count == c_FULL);
    // The first WAIT cycle (r_wd == 0) gives the core time to drop a stale done.
    assign w_done_q  = (r_state == c_ST_WAIT) && me_done && (r_wd != '0);
    assign w_push    = w_done_q && !abort;
    assign w_pop     = res_valid && res_ready;
    assign w_last_mb = (me_mb_x == c_X_LAST) && (me_mb_y == c_Y_LAST);
    assign me_start  = (r_state == c_ST_ISSUE) && !w_full && !abort;

    assign w_entry = {me_mb_x, me_mb_y, me_mv_x, me_mv_y, me_sad};
    assign w_head  = r_mem[r_rd_ptr];
    assign {w_h_x, w_h_y, w_h_mvx, w_h_mvy, w_h_sad} = w_head;

    // Head fields are forced to zero when empty so the outputs are defined after reset.
    assign res_valid = (r_count != '0);
    assign res_mb_x  = res_valid ? w_h_x   : '0;
    assign res_mb_y  = res_valid ? w_h_y   : '0;
    assign res_mv_x  = res_valid ? w_h_mvx : '0;
    assign res_mv_y  = res_valid ? w_h_mvy : '0;
    assign res_sad   = res_valid ? w_h_sad : '0;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Frame sequencing state machine: MB walk, watchdog, status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_wd          <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            timeout_err   <= 1'b0;
            cfg_err       <= 1'b0;
            mb_count      <= '0;
            me_frame_addr <= '0;
            me_ref_addr   <= '0;
            me_mb_x       <= '0;
            me_mb_y       <= '0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                r_state <= c_ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start) begin
                            timeout_err <= 1'b0;
                            if (frame_idx != 16'd0) begin
                                me_frame_addr <= w_frame_addr;
                                me_ref_addr   <= w_ref_addr;
                                me_mb_x       <= '0;
                                me_mb_y       <= '0;
                                mb_count      <= '0;
                                cfg_err       <= 1'b0;
                                busy          <= 1'b1;
                                r_state       <= c_ST_ISSUE;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    c_ST_ISSUE: begin
                        if (!w_full) begin
                            r_wd    <= '0;
                            r_state <= c_ST_WAIT;
                        end
                    end
                    c_ST_WAIT: begin
                        if (w_done_q) begin
                            if (mb_count != 16'hFFFF) begin
                                mb_count <= mb_count + 16'd1;
                            end
                            if (me_mb_x == c_X_LAST) begin
                                me_mb_x <= '0;
                                me_mb_y <= me_mb_y + c_MB_STEP;
                            end else begin
                                me_mb_x <= me_mb_x + c_MB_STEP;
                            end
                            r_state <= w_last_mb ? c_ST_DRAIN : c_ST_ISSUE;
                        end else if (r_wd == c_WD_LAST) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            r_state     <= c_ST_IDLE;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    c_ST_DRAIN: begin
                        if (r_count == '0) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= c_ST_IDLE;
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    // Result FIFO bookkeeping; abort flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (abort) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Result storage; the push is only issued when a slot is free.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

endmodule
`default_nettype wire
